// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle controller for the RISC-V lab datapath.
// Walks each instruction through FETCH/EXEC and, for memory ops, LOAD+WB
// or STORE, so the synchronous ROM and RAM latencies are honoured. It gates
// the datapath enables, halts on unknown opcodes, supports single-step
// debug and keeps a saturating count of retired instructions.
module cpu_sequencer #(
    parameter int ROM_LAT = 1,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [6:0]       opcode,
    input  logic             ctrl_regwrite,
    input  logic             ctrl_memread,
    input  logic             ctrl_memwrite,
    output logic             pc_clr,
    output logic             pc_we,
    output logic             rf_we,
    output logic             mem_rden,
    output logic             mem_wren,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_LOAD  = 3'd3,
        S_WB    = 3'd4,
        S_STORE = 3'd5,
        S_PAUSE = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    // Wait counters only need to reach LAT-1, so size them to that range.
    localparam int FW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int RW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_t           r_state;
    logic [FW-1:0]    r_fetchCnt;
    logic [RW-1:0]    r_ramCnt;
    logic [CNT_W-1:0] r_count;

    logic w_validOp;
    logic w_execRetire;
    logic w_retire;

    // Decode the opcode class and the retire condition for the current cycle.
    always_comb begin
        w_validOp    = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
                       (opcode == 7'b0100011) || (opcode == 7'b0000011) ||
                       (opcode == 7'b1100011) || (opcode == 7'b1101111) ||
                       (opcode == 7'b1100111);
        w_execRetire = (r_state == S_EXEC) && w_validOp &&
                       !ctrl_memread && !ctrl_memwrite;
        w_retire     = w_execRetire || (r_state == S_WB) || (r_state == S_STORE);
    end

    // Sequencer state, latency counters and the retired-instruction counter.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetchCnt <= '0;
            r_ramCnt   <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_fetchCnt <= '0;
                        r_count    <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_fetchCnt == FW'(ROM_LAT - 1)) begin
                        r_state    <= S_EXEC;
                        r_fetchCnt <= '0;
                    end else begin
                        r_fetchCnt <= r_fetchCnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!w_validOp) begin
                        r_state <= S_HALT;
                    end else if (ctrl_memread) begin
                        r_state  <= S_LOAD;
                        r_ramCnt <= '0;
                    end else if (ctrl_memwrite) begin
                        r_state <= S_STORE;
                    end else begin
                        r_state    <= step_mode ? S_PAUSE : S_FETCH;
                        r_fetchCnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (r_ramCnt == RW'(RAM_LAT - 1)) begin
                        r_state  <= S_WB;
                        r_ramCnt <= '0;
                    end else begin
                        r_ramCnt <= r_ramCnt + 1'b1;
                    end
                end
                S_WB, S_STORE: begin
                    r_state    <= step_mode ? S_PAUSE : S_FETCH;
                    r_fetchCnt <= '0;
                end
                S_PAUSE: begin
                    if (step || !step_mode) begin
                        r_state    <= S_FETCH;
                        r_fetchCnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_retire && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Datapath enables decoded from the state; only EXEC looks at the opcode.
    always_comb begin
        pc_clr   = !reset && start && ((r_state == S_IDLE) || (r_state == S_HALT));
        pc_we    = w_retire;
        rf_we    = (w_execRetire && ctrl_regwrite) || (r_state == S_WB);
        mem_rden = (r_state == S_LOAD);
        mem_wren = (r_state == S_STORE);
        busy     = (r_state == S_FETCH) || (r_state == S_EXEC) ||
                   (r_state == S_LOAD)  || (r_state == S_WB)   ||
                   (r_state == S_STORE);
        halted   = (r_state == S_HALT);
    end

    assign state       = r_state;
    assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: the bench plays the ROM/control_unit side,
// queues the expected outcome of every instruction from a per-class model
// and a separate monitor checks each commit or halt against that queue.
module tb_cpu_sequencer;

    localparam int ROM_LAT = 1;
    localparam int RAM_LAT = 2;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLOCK_50;
    logic             reset;
    logic             start;
    logic             step_mode;
    logic             step;
    logic [6:0]       opcode;
    logic             ctrl_regwrite;
    logic             ctrl_memread;
    logic             ctrl_memwrite;
    logic             pc_clr;
    logic             pc_we;
    logic             rf_we;
    logic             mem_rden;
    logic             mem_wren;
    logic             busy;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    typedef struct {
        bit isHalt;
        bit rfWe;
        bit memWren;
        int rdenCycles;
        int busyCycles;
        int countBefore;
    } exp_t;

    exp_t expQ[$];
    int   checks;
    int   errors;
    logic expClr;
    int   retired;

    cpu_sequencer #(
        .ROM_LAT(ROM_LAT),
        .RAM_LAT(RAM_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .start        (start),
        .step_mode    (step_mode),
        .step         (step),
        .opcode       (opcode),
        .ctrl_regwrite(ctrl_regwrite),
        .ctrl_memread (ctrl_memread),
        .ctrl_memwrite(ctrl_memwrite),
        .pc_clr       (pc_clr),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .busy         (busy),
        .halted       (halted),
        .state        (state),
        .instr_count  (instr_count)
    );

    // Free-running 100 MHz clock.
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] randomInvalid();
        logic [6:0] op;
        do begin
            op = 7'($urandom);
        end while (op inside {7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
                              7'b1100011, 7'b1101111, 7'b1100111});
        return op;
    endfunction

    // Pulse start from IDLE/HALT; afterwards the DUT is in its first FETCH cycle.
    task automatic doStart();
        start   = 1'b1;
        expClr  = 1'b1;
        retired = 0;
        @(posedge CLOCK_50); #1;
        start  = 1'b0;
        expClr = 1'b0;
    endtask

    // One instruction from FETCH entry. cls: 0 R, 1 I, 2 B, 3 JAL, 4 JALR,
    // 5 load, 6 store, 7 random invalid, 8 opcode zero. rw: 0/1 forced, 2 random.
    task automatic applyStimulus(input int cls, input int rw, input bit sm,
                                 input int pauseLen, input int resumeMode);
        exp_t e;
        int   dur;
        step_mode     = sm;
        ctrl_regwrite = (rw == 2) ? 1'($urandom % 2) : (rw != 0);
        ctrl_memread  = 1'b0;
        ctrl_memwrite = 1'b0;
        case (cls)
            0: opcode = 7'b0110011;
            1: opcode = 7'b0010011;
            2: opcode = 7'b1100011;
            3: opcode = 7'b1101111;
            4: opcode = 7'b1100111;
            5: begin opcode = 7'b0000011; ctrl_memread  = 1'b1; end
            6: begin opcode = 7'b0100011; ctrl_memwrite = 1'b1; end
            8: opcode = 7'b0000000;
            default: begin
                opcode        = randomInvalid();
                ctrl_memread  = 1'($urandom % 2);
                ctrl_memwrite = 1'($urandom % 2);
            end
        endcase
        e.isHalt      = 1'b0;
        e.rfWe        = 1'b0;
        e.memWren     = 1'b0;
        e.rdenCycles  = 0;
        e.countBefore = retired;
        if (cls == 5) begin
            dur          = ROM_LAT + 1 + RAM_LAT + 1;
            e.rfWe       = 1'b1;
            e.rdenCycles = RAM_LAT;
        end else if (cls == 6) begin
            dur       = ROM_LAT + 2;
            e.memWren = 1'b1;
        end else if (cls >= 7) begin
            dur      = ROM_LAT + 1;
            e.isHalt = 1'b1;
        end else begin
            dur    = ROM_LAT + 1;
            e.rfWe = ctrl_regwrite;
        end
        e.busyCycles = dur;
        expQ.push_back(e);
        // start and step are noise while busy: both must be ignored here.
        for (int c = 0; c < dur; c++) begin
            start = (($urandom % 8) == 0);
            step  = (($urandom % 4) == 0);
            @(posedge CLOCK_50); #1;
        end
        start = 1'b0;
        step  = 1'b0;
        if (!e.isHalt) begin
            retired = (retired < CNT_MAX) ? retired + 1 : CNT_MAX;
            if (sm) begin
                checkOutput("pause_entry_state", int'(state), 6);
                for (int p = 0; p < pauseLen; p++) begin
                    @(posedge CLOCK_50); #1;
                end
                checkOutput("pause_hold_state", int'(state), 6);
                if (resumeMode != 1) step = 1'b1;
                if (resumeMode != 0) step_mode = 1'b0;
                @(posedge CLOCK_50); #1;
                step = 1'b0;
                checkOutput("resume_fetch_state", int'(state), 1);
            end
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard pops on commit and halt.
    initial begin
        int   busyCnt;
        int   rdenCnt;
        bit   prevHalted;
        exp_t e;
        busyCnt    = 0;
        rdenCnt    = 0;
        prevHalted = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                busyCnt    = 0;
                rdenCnt    = 0;
                prevHalted = 1'b0;
                checkOutput("reset_outputs",
                            int'({pc_clr, pc_we, rf_we, mem_rden, mem_wren, busy, halted}), 0);
                continue;
            end
            checkOutput("pc_clr", int'(pc_clr), int'(expClr));
            if (busy) busyCnt++;
            if (mem_rden) rdenCnt++;
            if (!busy) checkOutput("idle_enables", int'({pc_we, rf_we, mem_rden, mem_wren}), 0);
            checkOutput("we_exclusion",
                        int'((rf_we && mem_wren) || ((rf_we || mem_wren) && !pc_we)), 0);
            if (pc_we) begin
                checkOutput("commit_expected", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("commit_not_halt", 0, int'(e.isHalt));
                    checkOutput("commit_rf_we", int'(rf_we), int'(e.rfWe));
                    checkOutput("commit_mem_wren", int'(mem_wren), int'(e.memWren));
                    checkOutput("rden_cycles", rdenCnt, e.rdenCycles);
                    checkOutput("instr_cycles", busyCnt, e.busyCycles);
                    checkOutput("count_before_retire", int'(instr_count), e.countBefore);
                end
                busyCnt = 0;
                rdenCnt = 0;
            end
            if (halted && !prevHalted) begin
                checkOutput("halt_expected", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("halt_not_commit", 1, int'(e.isHalt));
                    checkOutput("halt_cycles", busyCnt, e.busyCycles);
                    checkOutput("halt_rden", rdenCnt, 0);
                    checkOutput("halt_count", int'(instr_count), e.countBefore);
                    checkOutput("halt_state", int'(state), 7);
                end
                busyCnt = 0;
                rdenCnt = 0;
            end
            prevHalted = halted;
        end
    end

    // Main stimulus: directed scenarios followed by a randomized program.
    initial begin
        int cls;
        checks        = 0;
        errors        = 0;
        expClr        = 1'b0;
        retired       = 0;
        reset         = 1'b1;
        start         = 1'b0;
        step_mode     = 1'b0;
        step          = 1'b0;
        opcode        = 7'd0;
        ctrl_regwrite = 1'b0;
        ctrl_memread  = 1'b0;
        ctrl_memwrite = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_count", int'(instr_count), 0);
        reset = 1'b0;

        doStart();
        applyStimulus(1, 1, 1'b0, 0, 0);
        applyStimulus(5, 2, 1'b0, 0, 0);
        applyStimulus(6, 2, 1'b0, 0, 0);
        applyStimulus(2, 0, 1'b1, 10, 0);
        applyStimulus(8, 2, 1'b0, 0, 0);
        doStart();
        for (int i = 0; i < 5; i++) applyStimulus(i, 1, 1'b0, 0, 0);

        // Reset asserted mid-LOAD must clear everything before the next edge.
        opcode        = 7'b0000011;
        ctrl_memread  = 1'b1;
        ctrl_memwrite = 1'b0;
        step_mode     = 1'b0;
        repeat (ROM_LAT + 1) begin
            @(posedge CLOCK_50); #1;
        end
        checkOutput("in_load_state", int'(state), 3);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_state", int'(state), 0);
        checkOutput("async_reset_rden", int'(mem_rden), 0);
        checkOutput("async_reset_count", int'(instr_count), 0);
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        doStart();

        for (int i = 0; i < 60; i++) begin
            cls = (($urandom % 10) == 0) ? 7 : int'($urandom % 7);
            applyStimulus(cls, 2, (($urandom % 4) == 0), int'($urandom % 5),
                          int'($urandom % 3));
            if (cls >= 7) doStart();
        end
        applyStimulus(7, 2, 1'b0, 0, 0);
        repeat (3) begin
            @(posedge CLOCK_50); #1;
        end
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("final_count", int'(instr_count), retired);
        checkOutput("final_halted", int'(halted), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
